// File: rtl/sample_bank_loader_if.sv
// Sample-stream (valid/ready) and bank I SRAM write bus shared by the loader and its environment.
interface sample_bank_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] sram_write_addr;
  logic [DATA_W-1:0] sram_write_data;
  logic              sram_write_en;

  modport master (
    output s_valid, s_data,
    input  s_ready, sram_write_addr, sram_write_data, sram_write_en
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, sram_write_addr, sram_write_data, sram_write_en
  );
endinterface

// File: rtl/sample_bank_loader.sv
// Ping-pong loader for bank I: fills one half-bank while the DSP drains the other, flags each frame.
// Optional OVERRUN_DROP_EN: while blocked, accept and discard samples and raise a sticky overrun flag.
module sample_bank_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic [ADDR_W-1:0]   frame_len_i,
  input  logic                frame_ack_i,
  output logic                frame_done_o,
  output logic [ADDR_W-1:0]   frame_base_o,
  output logic [1:0]          full_cnt_o,
  output logic                overrun_o,
  sample_bank_loader_if.slave bus
);
  localparam logic [ADDR_W-1:0] HALF_C = ADDR_W'(1) << (ADDR_W-1);
  localparam logic [ADDR_W-2:0] ONE_C  = (ADDR_W-1)'(1);

  typedef enum logic [1:0] {IDLE, FILL, BLOCKED} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-2:0]   len_m1_q, len_m1_d;
  logic [ADDR_W-2:0]   count_q, count_d;
  logic                wr_half_q, wr_half_d;
  logic                rd_half_q, rd_half_d;
  logic [1:0]          full_q, full_d;
  logic [1:0]          full_cnt_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                done_q;
  logic [ADDR_W-1:0]   base_q;
  logic                ready;
  logic                wr_xfer;
  logic                last;
  logic                ack_ok;

`ifdef OVERRUN_DROP_EN
  logic overrun_q;
  logic drop;
  assign ready = (state_q == FILL) || (state_q == BLOCKED);
  assign drop  = bus.s_valid && (state_q == BLOCKED);
`else
  assign ready = (state_q == FILL);
`endif

  assign wr_xfer = bus.s_valid && ready && (state_q == FILL);
  assign last    = wr_xfer && (count_q == len_m1_q);
  assign ack_ok  = frame_ack_i && (full_q != 2'b00);

  always_comb begin
    state_d   = state_q;
    len_m1_d  = len_m1_q;
    count_d   = count_q;
    wr_half_d = wr_half_q;
    rd_half_d = rd_half_q;
    full_d    = full_q;

    // Ack is applied before completion so a freshly freed half can be written straight away.
    if (ack_ok) begin
      full_d[rd_half_q] = 1'b0;
      rd_half_d         = ~rd_half_q;
    end
    if (wr_xfer) count_d = count_q + ONE_C;
    if (last) begin
      count_d           = '0;
      full_d[wr_half_q] = 1'b1;
      wr_half_d         = ~wr_half_q;
    end

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (enable_i) begin
          if (frame_len_i == '0 || frame_len_i > HALF_C) len_m1_d = '1;
          else                                          len_m1_d = frame_len_i[ADDR_W-2:0] - ONE_C;
          state_d = full_d[wr_half_q] ? BLOCKED : FILL;
        end
      end
      FILL: begin
        if (!enable_i) begin
          state_d = IDLE;
          count_d = '0;
        end else if (last && full_d[wr_half_d]) begin
          state_d = BLOCKED;
        end
      end
      BLOCKED: begin
        if (!enable_i) begin
          state_d = IDLE;
          count_d = '0;
        end else if (!full_d[wr_half_q]) begin
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      len_m1_q   <= '0;
      count_q    <= '0;
      wr_half_q  <= 1'b0;
      rd_half_q  <= 1'b0;
      full_q     <= 2'b00;
      full_cnt_q <= 2'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      base_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_m1_q   <= len_m1_d;
      count_q    <= count_d;
      wr_half_q  <= wr_half_d;
      rd_half_q  <= rd_half_d;
      full_q     <= full_d;
      full_cnt_q <= {1'b0, full_d[0]} + {1'b0, full_d[1]};
      wr_en_q    <= wr_xfer;
      done_q     <= last;
      if (wr_xfer) begin
        wr_addr_q <= {wr_half_q, count_q};
        wr_data_q <= bus.s_data;
      end
      if (last) base_q <= {wr_half_q, {(ADDR_W-1){1'b0}}};
    end
  end

`ifdef OVERRUN_DROP_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   overrun_q <= 1'b0;
    else if (drop) overrun_q <= 1'b1;
  end
  assign overrun_o = overrun_q;
`else
  assign overrun_o = 1'b0;
`endif

  assign bus.s_ready         = ready;
  assign bus.sram_write_en   = wr_en_q;
  assign bus.sram_write_addr = wr_addr_q;
  assign bus.sram_write_data = wr_data_q;
  assign frame_done_o        = done_q;
  assign frame_base_o        = base_q;
  assign full_cnt_o          = full_cnt_q;
endmodule

// File: tb/tb_sample_bank_loader.sv
// Directed bench for sample_bank_loader: reset, framing, full-bank fill, blocking, ack overlap, overrun.
module tb_sample_bank_loader;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [ADDR_W-1:0] frame_len;
  logic              frame_ack;
  logic              frame_done;
  logic [ADDR_W-1:0] frame_base;
  logic [1:0]        full_cnt;
  logic              overrun;
  int                n_vec = 0;
  int                n_err = 0;

  sample_bank_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sample_bank_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .frame_len_i  (frame_len),
    .frame_ack_i  (frame_ack),
    .frame_done_o (frame_done),
    .frame_base_o (frame_base),
    .full_cnt_o   (full_cnt),
    .overrun_o    (overrun),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample; it must be written on the next cycle at exp_addr.
  task automatic send(input logic [15:0] d, input logic [31:0] exp_addr, input logic exp_done);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    tick();
    chk("wr_en",   32'(bus.sram_write_en), 32'd1);
    chk("wr_addr", 32'(bus.sram_write_addr), exp_addr);
    chk("wr_data", 32'(bus.sram_write_data), 32'(d));
    chk("done",    32'(frame_done), 32'(exp_done));
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    enable      = 1'b0;
    frame_ack   = 1'b0;
    rst_n       = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    frame_len   = 10'd4;
    frame_ack   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    #1;
    chk("rst_ready",    32'(bus.s_ready), 32'd0);
    chk("rst_wr_en",    32'(bus.sram_write_en), 32'd0);
    chk("rst_full_cnt", 32'(full_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Four-sample frames: half 0 then into half 1.
    enable = 1'b1;
    tick();
    chk("fill_ready", 32'(bus.s_ready), 32'd1);
    send(16'h00A0, 32'd0, 1'b0);
    send(16'h00A1, 32'd1, 1'b0);
    send(16'h00A2, 32'd2, 1'b0);
    send(16'h00A3, 32'd3, 1'b1);
    chk("t2_base", 32'(frame_base), 32'd0);
    chk("t2_full", 32'(full_cnt), 32'd1);
    send(16'h00A4, 32'd512, 1'b0);
    chk("t2_done_pulse", 32'(frame_done), 32'd0);

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(bus.sram_write_en), 32'd0);
    chk("arst_addr",  32'(bus.sram_write_addr), 32'd0);
    chk("arst_full",  32'(full_cnt), 32'd0);
    chk("arst_ready", 32'(bus.s_ready), 32'd0);
    bus.s_valid = 1'b0;
    enable      = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(bus.s_ready), 32'd0);

    // frame_len=0 selects a full half (512 words).
    frame_len = 10'd0;
    enable    = 1'b1;
    tick();
    for (int i = 0; i < 512; i++) send(16'(i + 16'h1000), 32'(i), (i == 511));
    chk("t3_base", 32'(frame_base), 32'd0);
    chk("t3_full", 32'(full_cnt), 32'd1);
    do_reset();

    // Two-sample frames with no ack: both halves fill, then loader blocks.
    frame_len = 10'd2;
    enable    = 1'b1;
    tick();
    frame_len = 10'd7;
    send(16'h00B0, 32'd0, 1'b0);
    send(16'h00B1, 32'd1, 1'b1);
    chk("t4_base0", 32'(frame_base), 32'd0);
    send(16'h00B2, 32'd512, 1'b0);
    send(16'h00B3, 32'd513, 1'b1);
    chk("t4_base1", 32'(frame_base), 32'd512);
    chk("t4_full2", 32'(full_cnt), 32'd2);
`ifdef OVERRUN_DROP_EN
    chk("t6_ready_blk", 32'(bus.s_ready), 32'd1);
    bus.s_data = 16'h00B4;
    tick();
    chk("t6_no_write", 32'(bus.sram_write_en), 32'd0);
    chk("t6_overrun",  32'(overrun), 32'd1);
    bus.s_valid = 1'b0;
    tick();
    chk("t6_sticky", 32'(overrun), 32'd1);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("t4_full_ack", 32'(full_cnt), 32'd1);
    send(16'h00B4, 32'd0, 1'b0);
`else
    chk("t4_ready_blk", 32'(bus.s_ready), 32'd0);
    bus.s_data = 16'h00B4;
    tick();
    chk("t4_no_write", 32'(bus.sram_write_en), 32'd0);
    chk("t4_overrun",  32'(overrun), 32'd0);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("t4_ready_ack", 32'(bus.s_ready), 32'd1);
    chk("t4_full_ack",  32'(full_cnt), 32'd1);
    tick();
    chk("t4_wr_en",   32'(bus.sram_write_en), 32'd1);
    chk("t4_wr_addr", 32'(bus.sram_write_addr), 32'd0);
    chk("t4_wr_data", 32'(bus.sram_write_data), 32'h00B4);
`endif
    bus.s_valid = 1'b0;

    // Free half 1, then complete half 0 and half 1 with the ack of half 0 overlapping.
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("t5_full0", 32'(full_cnt), 32'd0);
    send(16'h00C0, 32'd1, 1'b1);
    chk("t5_full1", 32'(full_cnt), 32'd1);
    send(16'h00C1, 32'd512, 1'b0);
    frame_ack = 1'b1;
    send(16'h00C2, 32'd513, 1'b1);
    frame_ack = 1'b0;
    chk("t5_base",  32'(frame_base), 32'd512);
    chk("t5_full",  32'(full_cnt), 32'd1);
    chk("t5_ready", 32'(bus.s_ready), 32'd1);
    send(16'h00C3, 32'd0, 1'b0);
    bus.s_valid = 1'b0;
    tick();
    chk("idle_wr_en", 32'(bus.sram_write_en), 32'd0);

    // Dropping enable returns to IDLE and stops accepting.
    enable = 1'b0;
    tick();
    chk("dis_ready", 32'(bus.s_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
